// File: rtl/bt_radio_pkg.sv
// bt_radio_pkg: shared types and constants for the receive-side radio model.
// Holds the synthesizer state encoding, the channel count, the idle symbol
// and the constants of the optional noise LFSR (BTRADIO_RX_NOISE_EN).
package bt_radio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOCKED = 2'd2
   } bt_rx_state_e;

   localparam int          BT_NUM_CH    = 79;
   localparam logic [2:0]  BT_IDLE_SYM  = 3'b000;

   // Fibonacci LFSR, polynomial taps 16,14,13,11 -> state bits 15,13,12,10
   localparam logic [15:0] BT_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] BT_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/bt_radio_lfsr16.sv
// bt_radio_lfsr16: free-running 16-bit Fibonacci LFSR used as the noise
// source when BTRADIO_RX_NOISE_EN is defined. Shifts left, feedback enters
// at bit 0. The seed is a parameter so the async reset loads a constant.
module bt_radio_lfsr16
   import bt_radio_pkg::*;
#(
   parameter logic [15:0] SEED = BT_LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_en,
   output logic [15:0] o_state
);

   logic [15:0] r_state;
   logic        w_fb;

   assign w_fb    = ^(r_state & BT_LFSR_TAPS);
   assign o_state = r_state;

   // advance one step per enabled clock, reseed on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SEED;
      end else if (i_en) begin
         r_state <= {r_state[14:0], w_fb};
      end
   end

endmodule

// File: rtl/bt_radio_rx.sv
// bt_radio_rx: receive-side radio front end.
// Tunes a synthesizer model to the LC channel on loadfreq_p, waits out the
// PLL settle time counted in p_1us ticks, then forwards peer air symbols to
// the LC only while locked, rx-enabled, carrier present and on-channel.
// The forwarded symbol passes through a PIPE_DLY-deep register chain.
// Optional feature: `define BTRADIO_RX_NOISE_EN adds regi_noise_thr and an
// LFSR that flips bit0 of forwarded symbols to emulate bit errors.
// There is no valid/ready handshake: every signal is sampled every clk_6M.
module bt_radio_rx
   import bt_radio_pkg::*;
#(
   parameter int         PIPE_DLY = 1,
   parameter int         SETTLE_W = 10,
   parameter logic [2:0] IDLE_SYM = BT_IDLE_SYM
) (
   input  logic                clk_6M,
   input  logic                rstz,
   input  logic                p_1us,
   input  logic [SETTLE_W-1:0] regi_pllsetuptime,
   input  logic                loadfreq_p,
   input  logic [6:0]          lc_fk,
   input  logic                rxen,
   input  logic                air_txon,
   input  logic [6:0]          rxfk,
   input  logic [2:0]          rxsymbolin,
`ifdef BTRADIO_RX_NOISE_EN
   input  logic [7:0]          regi_noise_thr,
`endif
   output logic [2:0]          rxsymbolout,
   output logic                rx_locked,
   output logic                rx_match,
   output logic [6:0]          cur_fk,
   output logic [15:0]         mismatch_cnt,
   output logic [1:0]          o_dbg_state
);

   bt_rx_state_e        r_state;
   bt_rx_state_e        w_state_nxt;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic [SETTLE_W-1:0] w_settle_nxt;
   logic [6:0]          r_cur_fk;
   logic [15:0]         r_mis_cnt;
   logic [2:0]          r_sym_pipe  [PIPE_DLY];
   logic                r_gate_pipe [PIPE_DLY];

   logic                w_locked;
   logic                w_on_ch;
   logic                w_active;
   logic                w_gate;
   logic                w_mis_evt;
   logic [2:0]          w_sym0;

   assign w_locked  = (r_state == LOCKED);
   assign w_on_ch   = (rxfk == r_cur_fk);
   assign w_active  = w_locked & rxen & air_txon;
   assign w_gate    = w_active & w_on_ch;
   assign w_mis_evt = w_active & ~w_on_ch;

`ifdef BTRADIO_RX_NOISE_EN
   logic [15:0] w_lfsr;
   logic        w_flip;

   bt_radio_lfsr16 #(
      .SEED (BT_LFSR_SEED)
   ) u_lfsr (
      .clk     (clk_6M),
      .rst_n   (rstz),
      .i_en    (1'b1),
      .o_state (w_lfsr)
   );

   // low LFSR byte below the threshold marks an errored symbol
   assign w_flip = w_gate & (w_lfsr[7:0] < regi_noise_thr);
   assign w_sym0 = w_gate ? (rxsymbolin ^ {2'b00, w_flip}) : IDLE_SYM;
`else
   assign w_sym0 = w_gate ? rxsymbolin : IDLE_SYM;
`endif

   // synthesizer state and settle counter registers
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
      end
   end

   // next state: a retune wins over everything, SETTLE counts down p_1us
   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle_cnt;
      if (loadfreq_p) begin
         w_state_nxt  = SETTLE;
         w_settle_nxt = regi_pllsetuptime;
      end else begin
         case (r_state)
            SETTLE: begin
               if (r_settle_cnt == '0) begin
                  w_state_nxt = LOCKED;
               end else if (p_1us) begin
                  w_settle_nxt = r_settle_cnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // tuned channel and saturating off-channel counter
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_cur_fk  <= '0;
         r_mis_cnt <= '0;
      end else if (loadfreq_p) begin
         r_cur_fk  <= lc_fk;
         r_mis_cnt <= '0;
      end else if (w_mis_evt && (r_mis_cnt != 16'hFFFF)) begin
         r_mis_cnt <= r_mis_cnt + 16'd1;
      end
   end

   // gated symbol and gate state delay line, flushed to idle on reset
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         for (int i = 0; i < PIPE_DLY; i++) begin
            r_sym_pipe[i]  <= IDLE_SYM;
            r_gate_pipe[i] <= 1'b0;
         end
      end else begin
         r_sym_pipe[0]  <= w_sym0;
         r_gate_pipe[0] <= w_gate;
         for (int i = 1; i < PIPE_DLY; i++) begin
            r_sym_pipe[i]  <= r_sym_pipe[i-1];
            r_gate_pipe[i] <= r_gate_pipe[i-1];
         end
      end
   end

   assign rxsymbolout  = r_sym_pipe[PIPE_DLY-1];
   assign rx_match     = r_gate_pipe[PIPE_DLY-1];
   assign rx_locked    = w_locked;
   assign cur_fk       = r_cur_fk;
   assign mismatch_cnt = r_mis_cnt;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bt_radio_rx.sv
// tb_bt_radio_rx: bench for bt_radio_rx.
// A cycle model predicts the gated symbol/gate state for each driven cycle
// and pushes it to exp_q; the entry is popped and compared once the DUT has
// clocked it through the pipeline. Lock, channel and counter outputs are
// compared against the model every cycle, plus fixed-value checks at the
// points of interest (settle edge, saturation, async reset).
module tb_bt_radio_rx;
   import bt_radio_pkg::*;

   localparam int PIPE_DLY = 1;
   localparam int SETTLE_W = 10;

   // ---------------- clock / reset / DUT ----------------
   logic                clk_6M;
   logic                rstz;
   logic                p_1us;
   logic [SETTLE_W-1:0] regi_pllsetuptime;
   logic                loadfreq_p;
   logic [6:0]          lc_fk;
   logic                rxen;
   logic                air_txon;
   logic [6:0]          rxfk;
   logic [2:0]          rxsymbolin;
   logic [2:0]          rxsymbolout;
   logic                rx_locked;
   logic                rx_match;
   logic [6:0]          cur_fk;
   logic [15:0]         mismatch_cnt;
   logic [1:0]          o_dbg_state;
`ifdef BTRADIO_RX_NOISE_EN
   logic [7:0]          regi_noise_thr;
`endif

   initial clk_6M = 1'b0;
   always #5 clk_6M = ~clk_6M;

   bt_radio_rx #(
      .PIPE_DLY (PIPE_DLY),
      .SETTLE_W (SETTLE_W),
      .IDLE_SYM (3'b000)
   ) dut (
      .clk_6M            (clk_6M),
      .rstz              (rstz),
      .p_1us             (p_1us),
      .regi_pllsetuptime (regi_pllsetuptime),
      .loadfreq_p        (loadfreq_p),
      .lc_fk             (lc_fk),
      .rxen              (rxen),
      .air_txon          (air_txon),
      .rxfk              (rxfk),
      .rxsymbolin        (rxsymbolin),
`ifdef BTRADIO_RX_NOISE_EN
      .regi_noise_thr    (regi_noise_thr),
`endif
      .rxsymbolout       (rxsymbolout),
      .rx_locked         (rx_locked),
      .rx_match          (rx_match),
      .cur_fk            (cur_fk),
      .mismatch_cnt      (mismatch_cnt),
      .o_dbg_state       (o_dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   logic [3:0]          exp_q[$];   // {gate, symbol}
   bt_rx_state_e        m_state;
   logic [SETTLE_W-1:0] m_cnt;
   logic [6:0]          m_fk;
   logic [15:0]         m_mis;
   int                  us_div;
   int                  n_checks;
   int                  n_errors;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = IDLE;
      m_cnt   = '0;
      m_fk    = '0;
      m_mis   = '0;
      exp_q.delete();
   endtask

   // one clock: predict, clock, compare
   task automatic cyc();
      logic       locked;
      logic       gate;
      logic [3:0] e;
      locked = (m_state == LOCKED);
      gate   = locked && rxen && air_txon && (rxfk == m_fk);
      exp_q.push_back({gate, gate ? rxsymbolin : 3'b000});
      if (loadfreq_p) begin
         m_fk    = lc_fk;
         m_cnt   = regi_pllsetuptime;
         m_state = SETTLE;
         m_mis   = '0;
      end else begin
         if (locked && rxen && air_txon && (rxfk != m_fk) && (m_mis != 16'hFFFF))
            m_mis = m_mis + 16'd1;
         if (m_state == SETTLE) begin
            if (m_cnt == '0) m_state = LOCKED;
            else if (p_1us)  m_cnt = m_cnt - 1'b1;
         end
      end
      @(posedge clk_6M);
      #1;
      if (exp_q.size() >= PIPE_DLY) begin
         e = exp_q.pop_front();
         check_val("rxsymbolout", rxsymbolout, e[2:0]);
         check_val("rx_match", rx_match, e[3]);
      end
      check_val("rx_locked", rx_locked, m_state == LOCKED);
      check_val("cur_fk", cur_fk, m_fk);
      check_val("mismatch_cnt", mismatch_cnt, m_mis);
      check_val("state", o_dbg_state, m_state);
   endtask

   // ---------------- driver tasks ----------------
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         p_1us      = (us_div == 5);
         us_div     = (us_div + 1) % 6;
         rxsymbolin = 3'($urandom_range(0, 7));
         cyc();
      end
      p_1us = 1'b0;
   endtask

   task automatic load(input logic [6:0] fk, input logic [SETTLE_W-1:0] setup);
      lc_fk             = fk;
      regi_pllsetuptime = setup;
      loadfreq_p        = 1'b1;
      p_1us             = 1'b0;
      cyc();
      loadfreq_p        = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_sym"},    rxsymbolout,  3'b000);
      check_val({tag, "_locked"}, rx_locked,    1'b0);
      check_val({tag, "_match"},  rx_match,     1'b0);
      check_val({tag, "_fk"},     cur_fk,       7'd0);
      check_val({tag, "_mis"},    mismatch_cnt, 16'd0);
      check_val({tag, "_state"},  o_dbg_state,  IDLE);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks          = 0;
      n_errors          = 0;
      us_div            = 0;
      rstz              = 1'b0;
      p_1us             = 1'b0;
      regi_pllsetuptime = '0;
      loadfreq_p        = 1'b0;
      lc_fk             = '0;
      rxen              = 1'b0;
      air_txon          = 1'b0;
      rxfk              = '0;
      rxsymbolin        = '0;
`ifdef BTRADIO_RX_NOISE_EN
      regi_noise_thr    = 8'd0;
`endif
      model_reset();

      // reset values
      #23;
      check_reset_outputs("reset");
      @(negedge clk_6M);
      rstz = 1'b1;
      @(posedge clk_6M);
      #1;

      // settle timing: lock exactly one clk after the 150th p_1us
      rxen     = 1'b1;
      air_txon = 1'b1;
      rxfk     = 7'd23;
      load(7'd23, 10'd150);
      check_val("settle_fk", cur_fk, 7'd23);
      for (int i = 1; i <= 150; i++) begin
         p_1us = 1'b1;
         cyc();
         p_1us = 1'b0;
         if (i == 150) check_val("lock_at_150th", rx_locked, 1'b0);
         else          repeat (5) cyc();
      end
      cyc();
      check_val("lock_after_150th", rx_locked, 1'b1);

      // matched passthrough, symbols 1..7
      for (int s = 1; s <= 7; s++) begin
         rxsymbolin = 3'(s);
         cyc();
         check_val("pass_sym", rxsymbolout, 32'(s));
         check_val("pass_match", rx_match, 1'b1);
      end

      // off-channel for 1000 cycles
      rxfk = 7'd24;
      run(1000);
      check_val("off_sym", rxsymbolout, 3'b000);
      check_val("off_mis_1000", mismatch_cnt, 16'd1000);

      // random mix of gate conditions
      for (int i = 0; i < 300; i++) begin
         rxen       = ($urandom_range(0, 3) != 0);
         air_txon   = ($urandom_range(0, 3) != 0);
         rxfk       = ($urandom_range(0, 1) != 0) ? 7'd23 : 7'd24;
         rxsymbolin = 3'($urandom_range(0, 7));
         cyc();
      end

      // loadfreq clears the off-channel counter
      rxen     = 1'b1;
      air_txon = 1'b1;
      rxfk     = 7'd23;
      load(7'd23, 10'd4);
      check_val("load_clr_mis", mismatch_cnt, 16'd0);
      run(40);
      check_val("relock_23", rx_locked, 1'b1);

      // retune mid-packet to channel 40 while the peer stays on 23
      run(5);
      rxsymbolin = 3'd6;
      load(7'd40, 10'd3);
      check_val("retune_last_sym", rxsymbolout, 3'd6);
      rxsymbolin = 3'd5;
      cyc();
      check_val("retune_idle", rxsymbolout, 3'b000);
      run(40);
      check_val("retune_locked", rx_locked, 1'b1);
      check_val("retune_offch_idle", rxsymbolout, 3'b000);
      rxfk       = 7'd40;
      rxsymbolin = 3'd5;
      cyc();
      rxsymbolin = 3'd2;
      cyc();
      check_val("retune_resume", rxsymbolout, 3'd2);

      // zero settle time: lock one cycle after the load
      load(7'd5, 10'd0);
      check_val("zero_settle_unlocked", rx_locked, 1'b0);
      cyc();
      check_val("zero_settle_locked", rx_locked, 1'b1);

      // saturation of the off-channel counter
      rxfk = 7'd6;
      run(70000);
      check_val("mis_saturated", mismatch_cnt, 16'hFFFF);
      run(10);
      check_val("mis_held", mismatch_cnt, 16'hFFFF);

      // async reset in the middle of a matched stream
      rxfk       = 7'd5;
      rxsymbolin = 3'd7;
      cyc();
      cyc();
      check_val("pre_reset_sym", rxsymbolout, 3'd7);
      #2;
      rstz = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      #1;
      rstz = 1'b1;

      // after reset: unlocked until the next load plus settle
      rxfk = 7'd0;
      run(50);
      check_val("post_rst_unlocked", rx_locked, 1'b0);
      check_val("post_rst_idle", rxsymbolout, 3'b000);
      load(7'd0, 10'd2);
      run(30);
      check_val("post_rst_relock", rx_locked, 1'b1);
      rxsymbolin = 3'd3;
      cyc();
      check_val("post_rst_pass", rxsymbolout, 3'd3);

      check_val("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bt_radio_rx.md
Name: bt_radio_rx

Overview:
- Behavioural/synthesizable receive-side radio front end. It is the receive direction of the radio model that turns LC tx symbols and hop frequency into air signals.
- Accepts the peer's air symbols and carrier frequency, tunes a local synthesizer model to the LC-requested channel, and waits out the PLL settle time.
- Forwards symbols to the LC rxsymbol input only while locked, rx-enabled and on the matching channel.
- Sits between the air side of the peer radio and bt_top.rxsymbol; one instance per device.

Parameters:
- PIPE_DLY, 1, output latency in clk_6M cycles from air symbol to rxsymbolout (legal 1..4).
- SETTLE_W, 10, width of the PLL settle counter; matches the regi_pllsetuptime width.
- IDLE_SYM, 3'b000, symbol driven when the gate is closed.

Ports:
- clk_6M  input  1  6 MHz system clock.
- rstz  input  1  asynchronous active-low reset.
- p_1us  input  1  one-cycle pulse every 1 us.
- regi_pllsetuptime  input  SETTLE_W  PLL settle time in us.
- loadfreq_p  input  1  one-cycle pulse: retune to lc_fk.
- lc_fk  input  7  LC-requested RF channel, 0..78.
- rxen  input  1  LC receive window active.
- air_txon  input  1  peer carrier present.
- rxfk  input  7  peer transmit channel.
- rxsymbolin  input  3  peer air symbol.
- rxsymbolout  output  3  gated symbol to the LC.
- rx_locked  output  1  synthesizer settled on cur_fk.
- rx_match  output  1  registered gate state, aligned with rxsymbolout.
- cur_fk  output  7  currently tuned channel.
- mismatch_cnt  output  16  saturating count of off-channel cycles.

Behaviour:
- Reset values: rxsymbolout=IDLE_SYM, rx_locked=0, rx_match=0, cur_fk=0, mismatch_cnt=0. The state machine resets to IDLE and the settle counter to 0.
- States: IDLE, SETTLE, LOCKED.
- loadfreq_p in any state:
  - latch cur_fk<=lc_fk;
  - load settle_cnt<=regi_pllsetuptime;
  - clear mismatch_cnt;
  - go to SETTLE, with rx_locked=0 from the next cycle.
  - loadfreq_p takes priority over all other events in the same cycle.
- SETTLE:
  - decrement settle_cnt on each p_1us;
  - go to LOCKED in the cycle after settle_cnt==0 is observed. regi_pllsetuptime=0 therefore locks one cycle after the load.
  - p_1us coinciding with loadfreq_p does not decrement.
- LOCKED: rx_locked=1. Stays in LOCKED until the next loadfreq_p. There is no return to IDLE except by reset.
- Gate (combinational, stage 0): gate = rx_locked & rxen & air_txon & (rxfk==cur_fk).
  - Stage-0 data = gate ? rxsymbolin : IDLE_SYM.
  - Stage-0 data and gate pass through a PIPE_DLY-deep register chain; the last stage drives rxsymbolout/rx_match.
  - Latency is exactly PIPE_DLY cycles. Closing the gate mid-packet yields IDLE_SYM PIPE_DLY cycles later, with no truncation or extension.
- mismatch_cnt: +1 per cycle when rx_locked & rxen & air_txon & (rxfk!=cur_fk). Saturates at 16'hFFFF. Cleared by loadfreq_p.
- lc_fk changes without loadfreq_p are ignored.
- Values of rxfk/lc_fk above 78 are compared raw; no range check.
- Reset mid-SETTLE or mid-packet: all outputs return to their reset values immediately (asynchronously), and the pipeline is flushed to IDLE_SYM.

Optional Feature:
- Macro: BTRADIO_RX_NOISE_EN.
- When defined:
  - adds input regi_noise_thr [7:0];
  - adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1, advancing every clk_6M;
  - in stage 0, when gate=1 and lfsr[7:0] < regi_noise_thr, bit0 of the forwarded symbol is inverted;
  - regi_noise_thr=0 gives no errors.
- When undefined: no port, no LFSR, and the datapath is bit-exact with the gate equation above.

Decomposition:
- Package bt_radio_pkg holds:
  - the state enum (IDLE=2'd0, SETTLE=2'd1, LOCKED=2'd2);
  - BT_NUM_CH=79;
  - default IDLE_SYM;
  - LFSR seed/taps constants.
- One sub-module, bt_radio_lfsr16 (enable, seed, 16-bit state out), is instantiated only under BTRADIO_RX_NOISE_EN.

Test Plan:
- Settle timing:
  - Stimulus: regi_pllsetuptime=150, loadfreq_p with lc_fk=23.
  - Response: rx_locked rises exactly one clk after the 150th subsequent p_1us; cur_fk=23.
- Matched passthrough:
  - Stimulus: LOCKED, rxen=1, air_txon=1, rxfk=23, rxsymbolin stepping 1..7.
  - Response: rxsymbolout equals the same sequence delayed PIPE_DLY=1 cycle; rx_match=1.
- Off-channel:
  - Stimulus: rxfk=24, held for 1000 cycles.
  - Response: rxsymbolout=3'b000 and mismatch_cnt=1000.
  - Follow-up stimulus: loadfreq_p.
  - Response: mismatch_cnt=0.
- Retune mid-packet:
  - Stimulus: loadfreq_p during a matched stream.
  - Response: rxsymbolout goes to IDLE_SYM PIPE_DLY cycles after loadfreq_p, stays idle for the full settle time, and resumes only if rxfk equals the new lc_fk.
- Zero settle / saturation:
  - Stimulus: pllsetuptime=0.
  - Response: lock one cycle after load.
  - Stimulus: 70000 mismatch cycles.
  - Response: mismatch_cnt=16'hFFFF, held.
- Async reset:
  - Stimulus: rstz low mid-stream.
  - Response: all outputs at reset values in the same timestep.
  - Follow-up stimulus: rstz high.
  - Response: IDLE; rx_locked=0 until the next loadfreq_p plus settle.
  - Noise build only: regi_noise_thr=0 gives an error-free stream; regi_noise_thr=255 flips bit0 for all but ~1/256 of symbols.
